if_fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core. Holds the PC.

---
 rtl/if_fetch_stage.sv | 98 +++++++++
 tb/tb_if_fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register. It owns the PC and runs the
// instruction-memory request/ready handshake, the hazard stall and the ID-stage redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  ID_Jump,
  input  logic        ID_Branch,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  output logic [31:0] IMem_Addr,
  output logic        IMem_Req,
  input  logic [31:0] IMem_Data,
  input  logic        IMem_Ready,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        is_jr, is_j, redirect;
  logic [31:0] target, pc_plus4;

  // ID_Jump==11 falls through to sequential behaviour without redirecting.
  assign is_jr    = (ID_Jump == 2'b10);
  assign is_j     = (ID_Jump == 2'b01);
  assign redirect = (ID_Branch | is_j | is_jr) & ~stall;
  assign target   = is_jr ? JrTarget : (is_j ? JumpTarget : BranchTarget);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (stall) begin
      // Hold everything; memory data returned now is dropped and refetched later.
    end else if (redirect) begin
      pc_d    = target;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = S_FETCH;
    end else if (IMem_Ready && state_q != S_BOOT) begin
      instr_d = IMem_Data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      pc_d    = pc_plus4;
      state_d = S_FETCH;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      case (state_q)
        S_BOOT:  state_d = S_FETCH;
        S_FETCH: state_d = S_WAIT;
        default: state_d = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign IMem_Addr  = pc_q;
  assign IMem_Req   = (state_q != S_BOOT);
  assign IFID_Instr = instr_q;
  assign IFID_PC4   = pc4_q;
  assign IFID_Valid = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. Memory returns addr^KEY so that captured words identify
// their fetch address; an override injects a stale word for the abandoned-wait case.
module tb_if_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  ID_Jump;
  logic        ID_Branch;
  logic [31:0] BranchTarget, JumpTarget, JrTarget;
  logic [31:0] IMem_Addr;
  logic        IMem_Req;
  logic [31:0] IMem_Data;
  logic        IMem_Ready;
  logic [31:0] IFID_Instr, IFID_PC4;
  logic        IFID_Valid;

  logic        ovr_en;
  logic [31:0] ovr_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign IMem_Data = ovr_en ? ovr_val : (IMem_Addr ^ KEY);

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .ID_Jump(ID_Jump), .ID_Branch(ID_Branch),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JrTarget(JrTarget),
    .IMem_Addr(IMem_Addr), .IMem_Req(IMem_Req), .IMem_Data(IMem_Data),
    .IMem_Ready(IMem_Ready), .IFID_Instr(IFID_Instr), .IFID_PC4(IFID_PC4),
    .IFID_Valid(IFID_Valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks fetch address, IF/ID valid and (when valid) PC+4 and instruction word.
  task automatic chk_ifid(input string tag, input logic [31:0] addr, input logic vld,
                          input logic [31:0] pc4);
    chk({tag, ".addr"}, IMem_Addr, addr);
    chk({tag, ".valid"}, {31'd0, IFID_Valid}, {31'd0, vld});
    if (vld) begin
      chk({tag, ".pc4"}, IFID_PC4, pc4);
      chk({tag, ".instr"}, IFID_Instr, (pc4 - 32'd4) ^ KEY);
    end else begin
      chk({tag, ".nop"}, IFID_Instr, 32'h0);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; ID_Jump = 2'b00; ID_Branch = 1'b0;
    BranchTarget = 32'h300; JumpTarget = 32'h500; JrTarget = 32'h400;
    IMem_Ready = 1'b1; ovr_en = 1'b0; ovr_val = 32'h0;
    #12;
    chk("rst.req", {31'd0, IMem_Req}, 32'd0);
    chk("rst.pc4", IFID_PC4, 32'h0);
    chk_ifid("rst", 32'h0, 1'b0, 32'h0);

    // 1: boot cycle then sequential fetch
    @(negedge clk); reset = 1'b1;
    chk("boot.req", {31'd0, IMem_Req}, 32'd0);
    tick();
    chk("fetch.req", {31'd0, IMem_Req}, 32'd1);
    chk_ifid("boot", 32'h0, 1'b0, 32'h0);
    tick(); chk_ifid("seq0", 32'h4, 1'b1, 32'h4);
    tick(); chk_ifid("seq1", 32'h8, 1'b1, 32'h8);
    tick(); chk_ifid("seq2", 32'hC, 1'b1, 32'hC);
    tick(); chk_ifid("seq3", 32'h10, 1'b1, 32'h10);

    // 2: stall for two cycles at PC=0x10
    stall = 1'b1;
    tick(); chk_ifid("stall0", 32'h10, 1'b1, 32'h10);
    tick(); chk_ifid("stall1", 32'h10, 1'b1, 32'h10);
    stall = 1'b0;
    tick(); chk_ifid("resume", 32'h14, 1'b1, 32'h14);

    // 3: jr and branch together -> jr wins
    ID_Jump = 2'b10; ID_Branch = 1'b1;
    tick(); chk_ifid("jr", 32'h400, 1'b0, 32'h0);
    ID_Jump = 2'b00; ID_Branch = 1'b0;
    tick(); chk_ifid("jr.next", 32'h404, 1'b1, 32'h404);

    // 4: j to 0x20, memory waits, redirect to 0x80 abandons the wait
    ID_Jump = 2'b01; JumpTarget = 32'h20;
    tick(); chk_ifid("j20", 32'h20, 1'b0, 32'h0);
    ID_Jump = 2'b00; IMem_Ready = 1'b0;
    tick(); chk_ifid("wait0", 32'h20, 1'b0, 32'h0);
    tick(); chk_ifid("wait1", 32'h20, 1'b0, 32'h0);
    tick(); chk_ifid("wait2", 32'h20, 1'b0, 32'h0);
    chk("wait.req", {31'd0, IMem_Req}, 32'd1);
    ID_Branch = 1'b1; BranchTarget = 32'h80;
    IMem_Ready = 1'b1; ovr_en = 1'b1; ovr_val = 32'h20 ^ KEY;
    tick(); chk_ifid("br80", 32'h80, 1'b0, 32'h0);
    ID_Branch = 1'b0; ovr_en = 1'b0;
    tick(); chk_ifid("got80", 32'h84, 1'b1, 32'h84);

    // 5: stall beats branch; branch taken once stall drops
    stall = 1'b1; ID_Branch = 1'b1; BranchTarget = 32'h200;
    tick(); chk_ifid("stallbr", 32'h84, 1'b1, 32'h84);
    stall = 1'b0;
    tick(); chk_ifid("br200", 32'h200, 1'b0, 32'h0);
    ID_Branch = 1'b0;

    // ID_Jump=11 is sequential
    ID_Jump = 2'b11; JumpTarget = 32'h700; JrTarget = 32'h800;
    tick(); chk_ifid("jmp11", 32'h204, 1'b1, 32'h204);
    ID_Jump = 2'b00;

    // 6: PC wrap, then async reset mid-WAIT
    ID_Jump = 2'b10; JrTarget = 32'hFFFF_FFFC;
    tick(); chk_ifid("jrtop", 32'hFFFF_FFFC, 1'b0, 32'h0);
    ID_Jump = 2'b00;
    tick();
    chk("wrap.addr", IMem_Addr, 32'h0);
    chk("wrap.pc4", IFID_PC4, 32'h0);
    chk("wrap.instr", IFID_Instr, 32'hFFFF_FFFC ^ KEY);
    chk("wrap.valid", {31'd0, IFID_Valid}, 32'd1);
    IMem_Ready = 1'b0;
    tick(); chk_ifid("wrapwait", 32'h0, 1'b0, 32'h0);
    JrTarget = 32'h40; ID_Jump = 2'b10;
    tick(); ID_Jump = 2'b00;
    tick(); // now waiting at 0x40 with IF/ID holding bubble; capture a word first
    IMem_Ready = 1'b1;
    tick(); chk_ifid("pre.rst", 32'h44, 1'b1, 32'h44);
    IMem_Ready = 1'b0;
    tick(); // FETCH -> WAIT, PC=0x44
    #2 reset = 1'b0;
    #1;
    chk("arst.addr", IMem_Addr, 32'h0);
    chk("arst.req", {31'd0, IMem_Req}, 32'd0);
    chk("arst.instr", IFID_Instr, 32'h0);
    chk("arst.pc4", IFID_PC4, 32'h0);
    chk("arst.valid", {31'd0, IFID_Valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
